// File: rtl/la_rstseq_if.sv
// Sequenced-reset bundle between la_rstseq and its consumer: software reset
// request in, per-domain active-low resets and completion flag out.
interface la_rstseq_if #(
    parameter int N = 4
);
    logic         swrst;
    logic [N-1:0] nrst_out;
    logic         done;

    // Driver of the software reset and consumer of the sequenced resets.
    modport master (
        output swrst,
        input  nrst_out,
        input  done
    );

    // The reset sequencer itself.
    modport slave (
        input  swrst,
        output nrst_out,
        output done
    );
endinterface

// File: rtl/la_rstseq.sv
// Reset sequencer: synchronizes deassertion of the pad reset through a flop
// chain fed by a tie-high, then releases N reset domains one at a time,
// DELAY cycles apart, and raises done once every domain is out of reset.
module la_rstseq #(
    parameter string PROP   = "DEFAULT",
    parameter int    STAGES = 2,
    parameter int    N      = 4,
    parameter int    DELAY  = 16
) (
    input  logic          clk,
    input  logic          nreset,
    la_rstseq_if.slave    bus
);
    localparam int CW = $clog2(DELAY + 1);
    localparam int IW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [N-1:0]  BIT0     = N'(1'b1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [STAGES-1:0] sync_r;
    logic              sync_ok_s;
    logic              sync_next_s;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [IW-1:0]     idx_r;
    logic [N-1:0]      nrst_r;
    logic              done_r;

    // sync_ok is the last stage; sync_next is the value about to enter it.
    // Leaving HOLD on sync_next means the first counting edge is the one on
    // which sync_ok itself rises, so bit 0 releases STAGES+DELAY edges after
    // deassertion, and m+DELAY edges after the first edge with swrst low.
    assign sync_ok_s   = sync_r[STAGES-1];
    assign sync_next_s = sync_r[STAGES-2];

    // Reset-deassertion synchronizer: shift a constant 1 through the chain.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], 1'b1};
        end
    end

    // Release sequencer; all outputs come straight from these flops.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= HOLD;
            cnt_r   <= '0;
            idx_r   <= '0;
            nrst_r  <= '0;
            done_r  <= 1'b0;
        end else if (bus.swrst) begin
            // Software reset wins over any release due on this edge.
            state_r <= HOLD;
            cnt_r   <= '0;
            idx_r   <= '0;
            nrst_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    if (sync_next_s || sync_ok_s) begin
                        state_r <= COUNT;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                COUNT: begin
                    if (cnt_r == CNT_LAST) begin
                        nrst_r <= nrst_r | (BIT0 << idx_r);
                        cnt_r  <= '0;
                        idx_r  <= idx_r + IW'(1);
                        if (idx_r == IDX_LAST) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= COUNT;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= HOLD;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    nrst_r  <= '0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.nrst_out = nrst_r;
    assign bus.done     = done_r;
endmodule
